// File: rtl/checkpoint_recovery_unit.sv
// Branch-resolution front end of the checkpointer: validates correct branches and
// recovers from the oldest mispredict by recalling and unpacking its checkpoint line.
module checkpoint_recovery_unit #(
    parameter int unsigned NUM_CHECKPOINTS = 8,
    parameter int unsigned AL_SIZE         = 64,
    parameter int unsigned NUM_BR          = 2,
    parameter int unsigned DRAIN_CYCLES    = 2,
    localparam int unsigned CW             = $clog2(NUM_CHECKPOINTS),
    localparam int unsigned A              = $clog2(AL_SIZE),
    localparam int unsigned LINE_SIZE      = 3 * A + 596
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_valid      [NUM_BR],
    input  logic                 br_mispredict [NUM_BR],
    input  logic [CW-1:0]        br_ckpt_id    [NUM_BR],
    input  logic [31:0]          br_target     [NUM_BR],
    input  logic [CW-1:0]        ckpt_back,
    input  logic [LINE_SIZE-1:0] recalled_data,
    output logic                 validate      [NUM_BR],
    output logic [CW-1:0]        validated_id  [NUM_BR],
    output logic                 recall_checkpoint,
    output logic [CW-1:0]        recall_id,
    output logic                 restore_valid,
    output logic [5:0]           rst_free_list [64],
    output logic [6:0]           rst_fl_size,
    output logic [5:0]           rst_fl_front,
    output logic [5:0]           rst_fl_back,
    output logic [A-1:0]         rst_al_front,
    output logic [A:0]           rst_al_size,
    output logic [5:0]           rst_rmt       [32],
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic                 busy
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RECALL, RESTORE, DRAIN} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  p_id, p_id_next;
    logic [31:0]    p_target, p_target_next;
    logic [DW-1:0]  cnt, cnt_next;

    logic           cand_valid;
    logic [CW-1:0]  cand_id;
    logic [CW-1:0]  cand_age;
    logic [31:0]    cand_target;
    logic [CW-1:0]  p_age;
    logic           held;
    logic           accept;
    logic           validate_next [NUM_BR];

    // Slot A of the line carries a field the restore path does not use.
    logic           unused_line_bits;
    assign unused_line_bits = ^recalled_data[403+A +: A];

    // Distance from the oldest live checkpoint; wraps naturally in CW bits.
    function automatic logic [CW-1:0] age_of(input logic [CW-1:0] id, input logic [CW-1:0] back);
        return id - back;
    endfunction

    assign p_age  = age_of(p_id, ckpt_back);
    assign held   = (state != IDLE);
    assign accept = cand_valid && (!held || (cand_age < p_age));

    // Oldest mispredicting lane; strict compare keeps the lower lane on ties.
    always_comb begin
        cand_valid  = 1'b0;
        cand_id     = '0;
        cand_age    = '0;
        cand_target = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (br_valid[i] && br_mispredict[i] &&
                (!cand_valid || (age_of(br_ckpt_id[i], ckpt_back) < cand_age))) begin
                cand_valid  = 1'b1;
                cand_id     = br_ckpt_id[i];
                cand_age    = age_of(br_ckpt_id[i], ckpt_back);
                cand_target = br_target[i];
            end
        end
    end

    // Correct branches behind a winning or held mispredict are on the wrong path.
    always_comb begin
        for (int i = 0; i < NUM_BR; i++) begin
            validate_next[i] = br_valid[i] && !br_mispredict[i]
                && !(accept && (age_of(br_ckpt_id[i], ckpt_back) >= cand_age))
                && !(held && (age_of(br_ckpt_id[i], ckpt_back) > p_age));
        end
    end

    always_comb begin
        state_next    = state;
        p_id_next     = p_id;
        p_target_next = p_target;
        cnt_next      = cnt;
        if (accept) begin
            state_next    = RECALL;
            p_id_next     = cand_id;
            p_target_next = cand_target;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RECALL:  state_next = RESTORE;
                RESTORE: begin
                    state_next = DRAIN;
                    cnt_next   = DW'(DRAIN_CYCLES - 1);
                end
                DRAIN: begin
                    if (cnt == '0) state_next = IDLE;
                    else           cnt_next   = cnt - DW'(1);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            p_id              <= '0;
            p_target          <= '0;
            cnt               <= '0;
            recall_checkpoint <= 1'b0;
            recall_id         <= '0;
            restore_valid     <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            flush             <= 1'b0;
            busy              <= 1'b0;
            rst_fl_size       <= '0;
            rst_fl_front      <= '0;
            rst_fl_back       <= '0;
            rst_al_front      <= '0;
            rst_al_size       <= '0;
            for (int i = 0; i < NUM_BR; i++) begin
                validate[i]     <= 1'b0;
                validated_id[i] <= '0;
            end
            for (int i = 0; i < 64; i++) rst_free_list[i] <= '0;
            for (int i = 0; i < 32; i++) rst_rmt[i] <= '0;
        end else begin
            state             <= state_next;
            p_id              <= p_id_next;
            p_target          <= p_target_next;
            cnt               <= cnt_next;
            recall_checkpoint <= (state_next == RECALL);
            recall_id         <= (state_next == RECALL) ? p_id_next : '0;
            restore_valid     <= (state_next == RESTORE);
            redirect_valid    <= (state_next == RESTORE);
            redirect_pc       <= (state_next == RESTORE) ? p_target_next : '0;
            flush             <= (state_next != IDLE);
            busy              <= (state_next != IDLE);
            for (int i = 0; i < NUM_BR; i++) begin
                validate[i]     <= validate_next[i];
                validated_id[i] <= validate_next[i] ? br_ckpt_id[i] : '0;
            end
            // Recalled line is valid for recall_id while in RECALL.
            if (state == RECALL) begin
                for (int i = 0; i < 64; i++) rst_free_list[i] <= recalled_data[6*i +: 6];
                rst_fl_size  <= recalled_data[390:384];
                rst_fl_front <= recalled_data[396:391];
                rst_fl_back  <= recalled_data[402:397];
                rst_al_front <= recalled_data[403 +: A];
                rst_al_size  <= recalled_data[403+2*A +: A+1];
                for (int i = 0; i < 32; i++) rst_rmt[i] <= recalled_data[404+3*A+6*i +: 6];
            end
        end
    end

endmodule

// File: tb/tb_checkpoint_recovery_unit.sv
// Scoreboard bench for checkpoint_recovery_unit: directed recovery scenarios followed
// by random branch traffic, checked against a cycle-timeline reference model.
module tb_checkpoint_recovery_unit;

    localparam int NCK   = 8;
    localparam int NB    = 2;
    localparam int DRAIN = 2;
    localparam int AW    = 6;
    localparam int LW    = 3 * AW + 596;
    localparam int MAXC  = 8192;

    logic           clk = 1'b0;
    logic           reset;
    logic           br_valid      [NB];
    logic           br_mispredict [NB];
    logic [2:0]     br_ckpt_id    [NB];
    logic [31:0]    br_target     [NB];
    logic [2:0]     ckpt_back;
    logic [LW-1:0]  recalled_data;
    logic           validate      [NB];
    logic [2:0]     validated_id  [NB];
    logic           recall_checkpoint;
    logic [2:0]     recall_id;
    logic           restore_valid;
    logic [5:0]     rst_free_list [64];
    logic [6:0]     rst_fl_size;
    logic [5:0]     rst_fl_front;
    logic [5:0]     rst_fl_back;
    logic [AW-1:0]  rst_al_front;
    logic [AW:0]    rst_al_size;
    logic [5:0]     rst_rmt       [32];
    logic           redirect_valid;
    logic [31:0]    redirect_pc;
    logic           flush;
    logic           busy;

    always #5 clk = ~clk;

    checkpoint_recovery_unit dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_mispredict(br_mispredict),
        .br_ckpt_id(br_ckpt_id), .br_target(br_target),
        .ckpt_back(ckpt_back), .recalled_data(recalled_data),
        .validate(validate), .validated_id(validated_id),
        .recall_checkpoint(recall_checkpoint), .recall_id(recall_id),
        .restore_valid(restore_valid), .rst_free_list(rst_free_list),
        .rst_fl_size(rst_fl_size), .rst_fl_front(rst_fl_front),
        .rst_fl_back(rst_fl_back), .rst_al_front(rst_al_front),
        .rst_al_size(rst_al_size), .rst_rmt(rst_rmt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .busy(busy)
    );

    // Checkpoint contents held as fields; lines are packed from them.
    logic [5:0]    m_fl       [NCK][64];
    logic [6:0]    m_fl_size  [NCK];
    logic [5:0]    m_fl_front [NCK];
    logic [5:0]    m_fl_back  [NCK];
    logic [5:0]    m_al_front [NCK];
    logic [5:0]    m_al_back  [NCK];
    logic [6:0]    m_al_size  [NCK];
    logic [5:0]    m_rmt      [NCK][32];
    logic [LW-1:0] lines      [NCK];

    assign recalled_data = lines[recall_id];

    typedef struct {
        int          cyc;
        int          lane;
        int          id;
        logic [31:0] tgt;
    } ev_t;

    ev_t vq[$];
    ev_t cq[$];
    ev_t rq[$];
    bit  exp_busy [MAXC];
    int  m_pid = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  n_checks = 0;
    int  n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s @cycle %0d: got %s, expected %s", name, cyc, got, want);
    endtask

    function automatic int age(input int id);
        return (id - int'(ckpt_back) + NCK) % NCK;
    endfunction

    task automatic pack_line(input int k);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < 64; i++) l[6*i +: 6] = m_fl[k][i];
        l[384 +: 7]          = m_fl_size[k];
        l[391 +: 6]          = m_fl_front[k];
        l[397 +: 6]          = m_fl_back[k];
        l[403 +: AW]         = m_al_front[k];
        l[403+AW +: AW]      = m_al_back[k];
        l[403+2*AW +: AW+1]  = m_al_size[k];
        for (int i = 0; i < 32; i++) l[404+3*AW+6*i +: 6] = m_rmt[k][i];
        lines[k] = l;
    endtask

    // Reference model: one call per cycle with that cycle's inputs applied.
    task automatic model_cycle();
        int  c;
        int  pa;
        int  cl;
        int  ca;
        int  a;
        bit  held;
        bit  acc;
        c    = cyc;
        held = exp_busy[c];
        pa   = age(m_pid);
        cl   = -1;
        ca   = NCK;
        for (int i = 0; i < NB; i++)
            if (br_valid[i] && br_mispredict[i] && age(int'(br_ckpt_id[i])) < ca) begin
                cl = i;
                ca = age(int'(br_ckpt_id[i]));
            end
        acc = (cl >= 0) && (!held || ca < pa);
        for (int i = 0; i < NB; i++)
            if (br_valid[i] && !br_mispredict[i]) begin
                a = age(int'(br_ckpt_id[i]));
                if (!(acc && a >= ca) && !(held && a > pa))
                    vq.push_back('{c + 1, i, int'(br_ckpt_id[i]), 32'h0});
            end
        if (acc) begin
            while (cq.size() > 0 && cq[$].cyc > c) void'(cq.pop_back());
            while (rq.size() > 0 && rq[$].cyc > c) void'(rq.pop_back());
            cq.push_back('{c + 1, cl, int'(br_ckpt_id[cl]), 32'h0});
            rq.push_back('{c + 2, cl, int'(br_ckpt_id[cl]), br_target[cl]});
            for (int t = c + 1; t <= c + 2 + DRAIN; t++) exp_busy[t] = 1'b1;
            m_pid = int'(br_ckpt_id[cl]);
        end
    endtask

    task automatic model_reset();
        int c;
        c = cyc;
        while (vq.size() > 0 && vq[$].cyc > c) void'(vq.pop_back());
        while (cq.size() > 0 && cq[$].cyc > c) void'(cq.pop_back());
        while (rq.size() > 0 && rq[$].cyc > c) void'(rq.pop_back());
        for (int t = c + 1; t < MAXC; t++) exp_busy[t] = 1'b0;
    endtask

    task automatic check_fields(input int k);
        bit    ok;
        string s;
        ok = 1'b1;
        s  = "all fields";
        for (int i = 0; i < 64; i++)
            if (ok && rst_free_list[i] !== m_fl[k][i]) begin
                ok = 1'b0;
                s  = $sformatf("free_list[%0d]=%h want %h", i, rst_free_list[i], m_fl[k][i]);
            end
        for (int i = 0; i < 32; i++)
            if (ok && rst_rmt[i] !== m_rmt[k][i]) begin
                ok = 1'b0;
                s  = $sformatf("rmt[%0d]=%h want %h", i, rst_rmt[i], m_rmt[k][i]);
            end
        if (ok && {rst_fl_size, rst_fl_front, rst_fl_back, rst_al_front, rst_al_size} !==
                  {m_fl_size[k], m_fl_front[k], m_fl_back[k], m_al_front[k], m_al_size[k]}) begin
            ok = 1'b0;
            s  = $sformatf("sizes %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                           rst_fl_size, rst_fl_front, rst_fl_back, rst_al_front, rst_al_size,
                           m_fl_size[k], m_fl_front[k], m_fl_back[k], m_al_front[k], m_al_size[k]);
        end
        chk(ok, $sformatf("restore_fields ckpt %0d", k), s, "line contents of recalled checkpoint");
    endtask

    // Monitor: pops expected events when the DUT presents them.
    task automatic monitor();
        ev_t e;
        while (vq.size() > 0 && vq[0].cyc < cyc) begin
            e = vq.pop_front();
            chk(1'b0, $sformatf("validate lane%0d", e.lane), "no pulse", $sformatf("id %0d", e.id));
        end
        for (int i = 0; i < NB; i++) begin
            if (vq.size() > 0 && vq[0].cyc == cyc && vq[0].lane == i) begin
                e = vq.pop_front();
                chk(validate[i] === 1'b1 && int'(validated_id[i]) == e.id,
                    $sformatf("validate lane%0d", i),
                    $sformatf("v=%0b id=%0d", validate[i], validated_id[i]),
                    $sformatf("v=1 id=%0d", e.id));
            end else if (validate[i] !== 1'b0) begin
                chk(1'b0, $sformatf("validate lane%0d", i),
                    $sformatf("v=%0b id=%0d", validate[i], validated_id[i]), "no pulse");
            end
        end
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            e = cq.pop_front();
            chk(recall_checkpoint === 1'b1 && int'(recall_id) == e.id, "recall",
                $sformatf("req=%0b id=%0d", recall_checkpoint, recall_id),
                $sformatf("req=1 id=%0d", e.id));
        end else if (recall_checkpoint !== 1'b0) begin
            chk(1'b0, "recall", $sformatf("req=%0b id=%0d", recall_checkpoint, recall_id), "no request");
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            e = rq.pop_front();
            chk(restore_valid === 1'b1 && redirect_valid === 1'b1 && redirect_pc === e.tgt,
                "restore_redirect",
                $sformatf("rv=%0b dv=%0b pc=%h", restore_valid, redirect_valid, redirect_pc),
                $sformatf("rv=1 dv=1 pc=%h", e.tgt));
            check_fields(e.id);
        end else if (restore_valid !== 1'b0 || redirect_valid !== 1'b0) begin
            chk(1'b0, "restore_redirect",
                $sformatf("rv=%0b dv=%0b", restore_valid, redirect_valid), "no pulse");
        end
        chk(flush === exp_busy[cyc] && busy === exp_busy[cyc], "flush_busy",
            $sformatf("flush=%0b busy=%0b", flush, busy),
            $sformatf("flush=%0b busy=%0b", exp_busy[cyc], exp_busy[cyc]));
    endtask

    always @(negedge clk) if (mon_en) monitor();

    task automatic clear_in();
        for (int i = 0; i < NB; i++) begin
            br_valid[i]      = 1'b0;
            br_mispredict[i] = 1'b0;
            br_ckpt_id[i]    = '0;
            br_target[i]     = '0;
        end
    endtask

    task automatic set_lane(input int i, input bit m, input int id, input logic [31:0] t);
        br_valid[i]      = 1'b1;
        br_mispredict[i] = m;
        br_ckpt_id[i]    = 3'(id);
        br_target[i]     = t;
    endtask

    task automatic step();
        if (reset) model_reset();
        else       model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_in();
        repeat (n) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NCK; k++) begin
            for (int i = 0; i < 64; i++) m_fl[k][i] = 6'($urandom);
            for (int i = 0; i < 32; i++) m_rmt[k][i] = 6'($urandom);
            m_fl_size[k]  = 7'($urandom_range(0, 64));
            m_fl_front[k] = 6'($urandom);
            m_fl_back[k]  = 6'($urandom);
            m_al_front[k] = 6'($urandom);
            m_al_back[k]  = 6'($urandom);
            m_al_size[k]  = 7'($urandom_range(0, 64));
        end
        m_rmt[3][5]  = 6'h2A;
        m_fl_size[3] = 7'd64;
        m_al_size[3] = 7'd17;
        m_fl[3][63]  = 6'h3F;
        for (int k = 0; k < NCK; k++) pack_line(k);

        reset     = 1'b1;
        ckpt_back = 3'd0;
        clear_in();
        @(posedge clk);
        #1;
        chk(busy === 1'b0 && flush === 1'b0 && restore_valid === 1'b0 &&
            redirect_valid === 1'b0 && recall_checkpoint === 1'b0, "reset_ctrl",
            $sformatf("%0b%0b%0b%0b%0b", busy, flush, restore_valid, redirect_valid, recall_checkpoint),
            "00000");
        chk(validate[0] === 1'b0 && validate[1] === 1'b0, "reset_validate",
            $sformatf("%0b%0b", validate[0], validate[1]), "00");
        chk(rst_fl_size === 7'd0 && rst_al_size === 7'd0 && rst_rmt[5] === 6'd0 &&
            rst_free_list[63] === 6'd0 && redirect_pc === 32'd0 && recall_id === 3'd0,
            "reset_fields",
            $sformatf("%0d %0d %0d %0d %h %0d", rst_fl_size, rst_al_size, rst_rmt[5],
                      rst_free_list[63], redirect_pc, recall_id), "all zero");
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        idle(2);

        // Single mispredict; also exercises the unpack of checkpoint 3.
        ckpt_back = 3'd0;
        set_lane(0, 1'b1, 3, 32'h1000);
        step();
        idle(6);

        // Two mispredicts with wrapped ages: lane1 (age 1) beats lane0 (age 3).
        ckpt_back = 3'd6;
        set_lane(0, 1'b1, 1, 32'hAAAA_0000);
        set_lane(1, 1'b1, 7, 32'hBBBB_0000);
        step();
        idle(6);

        // Correct branch older than the mispredict is validated; younger one is not.
        ckpt_back = 3'd0;
        set_lane(0, 1'b0, 2, 32'h0);
        set_lane(1, 1'b1, 4, 32'h4000);
        step();
        idle(6);
        set_lane(0, 1'b0, 5, 32'h0);
        set_lane(1, 1'b1, 4, 32'h4400);
        step();
        idle(6);

        // Older mispredict during DRAIN restarts recovery; younger one is ignored.
        set_lane(0, 1'b1, 5, 32'h5000);
        step();
        idle(3);
        set_lane(0, 1'b1, 2, 32'h2000);
        step();
        idle(2);
        set_lane(1, 1'b1, 6, 32'h6000);
        step();
        idle(6);

        // Reset while in RECALL aborts the recovery.
        set_lane(0, 1'b1, 1, 32'h1111);
        step();
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(6);

        for (int n = 0; n < 2000; n++) begin
            if (!exp_busy[cyc] && $urandom_range(0, 15) == 0) ckpt_back = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NB; i++) begin
                br_valid[i]      = 1'($urandom_range(0, 1));
                br_mispredict[i] = ($urandom_range(0, 5) == 0);
                br_ckpt_id[i]    = 3'($urandom_range(0, 7));
                br_target[i]     = $urandom;
            end
            step();
        end
        reset = 1'b0;
        idle(10);

        chk(vq.size() == 0, "validate_queue_drained", $sformatf("%0d left", vq.size()), "0 left");
        chk(cq.size() == 0, "recall_queue_drained", $sformatf("%0d left", cq.size()), "0 left");
        chk(rq.size() == 0, "restore_queue_drained", $sformatf("%0d left", rq.size()), "0 left");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
